led_bank_arbiter: RTL and testbench

Time-shares the 10-bit LED bank (`LEDR`) between several pattern sources on the 50 MHz board clock. Each source raises a level request and presents its pattern; the arbiter grants the bank to one source at a time, round-robin, and forces rotation after a bounded hold time. It sits between the LED pattern generators and the `LEDR` pins in `top_level`.

---
 rtl/led_bank_arbiter_if.sv | 14 +
 rtl/led_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_led_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_bank_arbiter_if.sv
// LED bank arbitration bus: per-source requests and patterns in, owner grant and LED drive out.
interface led_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LED_W   = 10
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] pattern;
    logic [NUM_REQ-1:0]       grant;
    logic [LED_W-1:0]         LEDR;
    logic                     busy;

    modport master (output req, pattern, input grant, LEDR, busy);
    modport slave  (input req, pattern, output grant, LEDR, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sharing of the LED bank between pattern sources, with tick-based forced rotation.
// Optional blank interval between owners when LED_ARB_BLANK_EN is defined.
module led_bank_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LED_W     = 10,
    parameter int TICK_DIV  = 50000,
    parameter int MAX_TICKS = 1000
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    led_bank_arbiter_if.slave  bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_TICKS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

`ifdef LED_ARB_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, BLANK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1} state_t;
`endif

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d, ptr_q, ptr_d, owner_nxt;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                tick, release_own;
    logic [NUM_REQ-1:0]  owner_mask, others, grant_d;
    logic [LED_W-1:0]    ledr_d;
    logic [IDX_W:0]      pick;

    // Returns {found, index} of the first set bit of mask searching from start upward, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [IDX_W:0]       res;
        int                   s;
        dbl = {mask, mask} >> start;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                s = int'(start) + i;
                if (s >= NUM_REQ) s = s - NUM_REQ;
                res = {1'b1, s[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

    assign tick        = (cnt_q == CNT_LAST);
    assign owner_mask  = NUM_REQ'(1) << owner_q;
    assign others      = bus.req & ~owner_mask;
    assign owner_nxt   = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
    // A drop takes precedence; saturated hold only rotates when someone else is waiting.
    assign release_own = !(|(bus.req & owner_mask)) || ((hold_q == HOLD_MAX) && (|others));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        pick    = '0;
        grant_d = '0;
        ledr_d  = '0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick[IDX_W]) begin
                    state_d = OWN;
                    owner_d = pick[IDX_W-1:0];
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (release_own) begin
                    ptr_d = owner_nxt;
`ifdef LED_ARB_BLANK_EN
                    state_d = BLANK;
`else
                    pick = rr_pick(others, owner_nxt);
                    if (pick[IDX_W]) begin
                        owner_d = pick[IDX_W-1:0];
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else if (tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
`ifdef LED_ARB_BLANK_EN
            BLANK: begin
                if (tick) begin
                    pick = rr_pick(bus.req, ptr_q);
                    if (pick[IDX_W]) begin
                        state_d = OWN;
                        owner_d = pick[IDX_W-1:0];
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so a grant appears on the edge that decides it.
        if (state_d == OWN) begin
            grant_d = NUM_REQ'(1) << owner_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_d == IDX_W'(i)) ledr_d = bus.pattern[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            bus.grant <= '0;
            bus.LEDR  <= '0;
            bus.busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            bus.grant <= grant_d;
            bus.LEDR  <= ledr_d;
            bus.busy  <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: a behavioural model predicts grant/LEDR/busy per edge.
module tb_led_bank_arbiter;
    localparam int NREQ = 4;
    localparam int LW   = 10;
    localparam int TDIV = 4;
    localparam int MAXT = 3;
    localparam int S_IDLE  = 0;
    localparam int S_OWN   = 1;
    localparam int S_BLANK = 2;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [LW-1:0]   l;
        logic            b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb_q[$];
    int   m_state, m_owner, m_ptr, m_hold, m_cnt;

    led_bank_arbiter_if #(.NUM_REQ(NREQ), .LED_W(LW)) bus ();

    led_bank_arbiter #(
        .NUM_REQ(NREQ), .LED_W(LW), .TICK_DIV(TDIV), .MAX_TICKS(MAXT)
    ) dut (
        .CLOCK_50(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [NREQ-1:0] r, input int start);
        int idx;
        for (int i = 0; i < NREQ; i++) begin
            idx = (start + i) % NREQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_owner = 0; m_ptr = 0; m_hold = 0; m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic grant_to(input int w);
        m_state = S_OWN; m_owner = w; m_hold = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*LW-1:0] p);
        bit              tk;
        int              w;
        bit              rel;
        logic [NREQ-1:0] om;
        exp_t            e;
        tk    = (m_cnt == TDIV - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        om    = 4'b0001 << m_owner;
        case (m_state)
            S_IDLE: begin
                w = rr_search(r, m_ptr);
                if (w >= 0) grant_to(w);
            end
            S_OWN: begin
                rel = ((r & om) == 0) || (m_hold == MAXT && (r & ~om) != 0);
                if (rel) begin
                    m_ptr = (m_owner + 1) % NREQ;
`ifdef LED_ARB_BLANK_EN
                    m_state = S_BLANK;
`else
                    w = rr_search(r & ~om, m_ptr);
                    if (w >= 0) grant_to(w);
                    else m_state = S_IDLE;
`endif
                end else if (tk && m_hold < MAXT) begin
                    m_hold++;
                end
            end
            default: begin
                if (tk) begin
                    w = rr_search(r, m_ptr);
                    if (w >= 0) grant_to(w);
                    else m_state = S_IDLE;
                end
            end
        endcase
        e.g = (m_state == S_OWN) ? (4'b0001 << m_owner) : 4'b0000;
        e.l = (m_state == S_OWN) ? p[m_owner*LW +: LW] : '0;
        e.b = (m_state != S_IDLE);
        sb_q.push_back(e);
    endtask

    // Entered and left at a falling edge: drive, predict, let one rising edge pass, compare.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*LW-1:0] p);
        exp_t e;
        bus.req     = r;
        bus.pattern = p;
        model_step(r, p);
        @(posedge clk);
        #1;
        check_val("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("grant", 32'(bus.grant), 32'(e.g));
            check_val("LEDR",  32'(bus.LEDR),  32'(e.l));
            check_val("busy",  32'(bus.busy),  32'(e.b));
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("rst_grant", 32'(bus.grant), 32'd0);
        check_val("rst_LEDR",  32'(bus.LEDR),  32'd0);
        check_val("rst_busy",  32'(bus.busy),  32'd0);
        model_reset();
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [NREQ*LW-1:0] rand_pat();
        return {8'($urandom()), $urandom()};
    endfunction

    initial begin
        logic [NREQ*LW-1:0] pat;
        logic [NREQ-1:0]    cur_g, last_owner, r;
        int                 run_len, hold_for;
        total = 0;
        bad   = 0;
        bus.req     = '0;
        bus.pattern = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("por_grant", 32'(bus.grant), 32'd0);
        check_val("por_LEDR",  32'(bus.LEDR),  32'd0);
        check_val("por_busy",  32'(bus.busy),  32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source and pattern follow.
        pat = {10'h111, 10'h0F0, 10'h155, 10'h2AA};
        cycle(4'b0001, pat);
        check_val("single_grant", 32'(bus.grant), 32'h1);
        check_val("single_LEDR",  32'(bus.LEDR),  32'h2AA);
        check_val("single_busy",  32'(bus.busy),  32'h1);
        pat[9:0] = 10'h3FF;
        cycle(4'b0001, pat);
        check_val("follow_LEDR", 32'(bus.LEDR), 32'h3FF);
        for (int i = 0; i < 3; i++) cycle(4'b0001, pat);

        // Asynchronous reset in the middle of ownership, then idle.
        async_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0000, pat);
        check_val("post_rst_grant", 32'(bus.grant), 32'd0);

        // Simultaneous requests from reset, then drops.
        cycle(4'b1111, pat);
        check_val("all_grant", 32'(bus.grant), 32'h1);
        check_val("all_LEDR",  32'(bus.LEDR),  32'(pat[9:0]));
        cycle(4'b1110, pat);
`ifndef LED_ARB_BLANK_EN
        check_val("drop_grant", 32'(bus.grant), 32'h2);
        check_val("drop_LEDR",  32'(bus.LEDR),  32'(pat[19:10]));
`endif
        cycle(4'b0000, pat);
`ifndef LED_ARB_BLANK_EN
        check_val("dropall_busy", 32'(bus.busy), 32'd0);
`endif
        for (int i = 0; i < 6; i++) cycle(4'b0000, pat);

        // Forced rotation between sources 0 and 2 with changing patterns.
        cur_g = '0; last_owner = '0; run_len = 0;
        for (int n = 0; n < 100; n++) begin
            pat = rand_pat();
            cycle(4'b0101, pat);
            if (bus.grant != cur_g) begin
                if (cur_g != 0) check_val("rot_len", 32'(run_len >= 2*TDIV && run_len <= 3*TDIV + 1), 32'd1);
                if (bus.grant != 0) begin
                    if (last_owner != 0) check_val("rot_alt", 32'(bus.grant != last_owner), 32'd1);
                    last_owner = bus.grant;
                end
                cur_g = bus.grant;
                run_len = 1;
            end else begin
                run_len++;
            end
        end

        // Lone owner saturates, then a second request preempts at once.
        for (int i = 0; i < 10 * TDIV + 20; i++) cycle(4'b0001, pat);
        check_val("sat_hold_grant", 32'(bus.grant), 32'h1);
        cycle(4'b0011, pat);
`ifndef LED_ARB_BLANK_EN
        check_val("sat_rotate", 32'(bus.grant), 32'h2);
`endif
        for (int i = 0; i < 12; i++) cycle(4'b0011, pat);

        // Random request mixes.
        for (int blk = 0; blk < 40; blk++) begin
            r = 4'($urandom_range(0, 15));
            hold_for = $urandom_range(1, 20);
            for (int i = 0; i < hold_for; i++) begin
                if ($urandom_range(0, 3) == 0) pat = rand_pat();
                cycle(r, pat);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
